prio_encoder_pipe: RTL and testbench

- Parametrised, registered priority encoder; successor to the fixed 4-to-2 combinational encoder.
- Adds a selectable priority direction, valid/ready flow control with a one-entry output register, and zero-input and multi-hot flags.
- Adds a saturating output-toggle counter that feeds the power-estimation datapath with switching-activity counts.
- Sits between activity-sampling logic upstream and the estimation accumulator downstream.

---
 rtl/prio_encoder_pipe.sv | 109 ++++++++++
 tb/tb_prio_encoder_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with zero/multi-hot flags and a saturating out-toggle counter.
// Latency: 1 cycle from accept to out_valid, one result per cycle when out_ready stays high.
// Backpressure: one-entry output register; in_ready = !out_valid || out_ready, holds result while stalled.
module prio_encoder_pipe #(
  parameter int WIDTH     = 8,
  parameter int OUT_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             any,
  output logic             multi,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt
);

  // TOG_W holds popcount of an OUT_W-bit difference; SUM_W cannot overflow before saturation.
  localparam int TOG_W = $clog2(OUT_W + 1);
  localparam int SUM_W = CNT_W + TOG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [OUT_W-1:0] idx;
    logic             any;
    logic             multi;
  } res_t;

  res_t             res_q;
  res_t             res_nxt;
  logic             res_vld;
  logic             acc_vld;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [OUT_W-1:0] idx_diff;
  logic [TOG_W-1:0] tog_cnt;
  logic [SUM_W-1:0] cnt_sum;

  function automatic logic [OUT_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) r = OUT_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i]) r = OUT_W'(i);
    end
    return r;
  endfunction

  assign in_ready = !res_vld || out_ready;
  assign acc_vld  = in_valid && in_ready;

  always_comb begin
    res_nxt       = '0;
    res_nxt.idx   = encode(d);
    res_nxt.any   = |d;
    // Clearing the lowest set bit leaves something behind only if two or more were set.
    res_nxt.multi = |(d & (d - WIDTH'(1)));
  end

  always_comb begin
    idx_diff = res_nxt.idx ^ res_q.idx;
    tog_cnt  = '0;
    for (int i = 0; i < OUT_W; i++)
      tog_cnt = tog_cnt + TOG_W'(idx_diff[i]);
    cnt_sum = SUM_W'(cnt_q) + SUM_W'(tog_cnt);
    if (cnt_sum > SUM_W'(CNT_MAX))
      cnt_nxt = CNT_MAX;
    else
      cnt_nxt = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      res_vld <= 1'b0;
    end else if (acc_vld) begin
      res_q   <= res_nxt;
      res_vld <= 1'b1;
    end else if (out_ready) begin
      res_vld <= 1'b0;
    end
  end

  // A clear on the same edge as an accept discards that transfer's toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (acc_vld)
      cnt_q <= cnt_nxt;
  end

  assign out        = res_q.idx;
  assign any        = res_q.any;
  assign multi      = res_q.multi;
  assign out_valid  = res_vld;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: three instances (MSB-first, LSB-first, 3-bit counter) on shared stimulus.
module tb_prio_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  d = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready_m, any_m, multi_m, vld_m;
  logic [2:0]  out_m;
  logic [15:0] cnt_m;
  logic        in_ready_l, any_l, multi_l, vld_l;
  logic [2:0]  out_l;
  logic [15:0] cnt_l;
  logic        in_ready_s, any_s, multi_s, vld_s;
  logic [2:0]  out_s;
  logic [2:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_m),
    .out(out_m), .any(any_m), .multi(multi_m), .out_valid(vld_m),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .toggle_cnt(cnt_m));

  prio_encoder_pipe #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_l),
    .out(out_l), .any(any_l), .multi(multi_l), .out_valid(vld_l),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .toggle_cnt(cnt_l));

  prio_encoder_pipe #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_s),
    .out(out_s), .any(any_s), .multi(multi_s), .out_valid(vld_s),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .toggle_cnt(cnt_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Winning index from plain arithmetic: floor(log2) of the value or of its lowest set bit.
  function automatic int ref_idx(input logic [7:0] v, input bit msb);
    int x;
    x = int'(v);
    if (x == 0) return 0;
    if (msb) return $clog2(x + 1) - 1;
    return $clog2((x & -x) + 1) - 1;
  endfunction

  function automatic int sat_add(input int a, input int b, input int maxv);
    return (a + b > maxv) ? maxv : a + b;
  endfunction

  typedef struct {
    logic [7:0] d;
    int         o_msb;
    int         o_lsb;
    bit         any;
    bit         multi;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int m_out, l_out, m_cnt, l_cnt, s_cnt;
  bit m_vld, m_any, m_multi;

  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v.d = 8'(1 << i); v.o_msb = i; v.o_lsb = i; v.any = 1'b1; v.multi = 1'b0;
      tbl.push_back(v);
    end
    v.d = 8'b0101_0110; v.o_msb = 6; v.o_lsb = 1; v.any = 1'b1; v.multi = 1'b1; tbl.push_back(v);
    v.d = 8'h00;        v.o_msb = 0; v.o_lsb = 0; v.any = 1'b0; v.multi = 1'b0; tbl.push_back(v);
    v.d = 8'hFF;        v.o_msb = 7; v.o_lsb = 0; v.any = 1'b1; v.multi = 1'b1; tbl.push_back(v);
    v.d = 8'h81;        v.o_msb = 7; v.o_lsb = 0; v.any = 1'b1; v.multi = 1'b1; tbl.push_back(v);
    v.d = 8'h18;        v.o_msb = 4; v.o_lsb = 3; v.any = 1'b1; v.multi = 1'b1; tbl.push_back(v);

    // Reset and idle
    do_reset();
    chk("rst_out", out_m, 0);
    chk("rst_any", any_m, 0);
    chk("rst_multi", multi_m, 0);
    chk("rst_vld", vld_m, 0);
    chk("rst_cnt", cnt_m, 0);
    chk("rst_in_ready", in_ready_m, 1);

    // Table: one-hot sweep then priority/flag patterns, full throughput
    for (int i = 0; i < tbl.size(); i++) begin
      d = tbl[i].d; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("tbl_out_msb", out_m, tbl[i].o_msb);
      chk("tbl_out_lsb", out_l, tbl[i].o_lsb);
      chk("tbl_any", any_m, tbl[i].any);
      chk("tbl_multi", multi_m, tbl[i].multi);
      chk("tbl_vld", vld_m, 1);
      if (i == 7) begin
        chk("sweep_cnt_msb", cnt_m, 11);
        chk("sweep_cnt_lsb", cnt_l, 11);
      end
    end

    // Backpressure and drain
    do_reset();
    d = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("bp_first_out", out_m, 4);
    chk("bp_first_cnt", cnt_m, 1);
    d = 8'h01; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_out", out_m, 4);
      chk("bp_hold_vld", vld_m, 1);
      chk("bp_hold_in_ready", in_ready_m, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready_m, 1);
    tick();
    chk("bp_second_out", out_m, 0);
    chk("bp_second_cnt", cnt_m, 2);
    in_valid = 1'b0; d = 8'h80;
    tick();
    chk("drain_vld", vld_m, 0);
    chk("drain_out_held", out_m, 0);
    chk("drain_any_held", any_m, 1);
    chk("drain_cnt_held", cnt_m, 2);

    // Saturation and clear on a 3-bit counter
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    d = 8'h80; tick(); chk("sat_cnt_1", cnt_s, 3);
    d = 8'h01; tick(); chk("sat_cnt_2", cnt_s, 6);
    d = 8'h80; tick(); chk("sat_cnt_3", cnt_s, 7);
    d = 8'h01; tick(); chk("sat_cnt_hold", cnt_s, 7);
    chk("nosat_cnt_wide", cnt_m, 12);
    d = 8'h80; cnt_clr = 1'b1; tick();
    chk("clr_cnt_sat", cnt_s, 0);
    chk("clr_cnt_wide", cnt_m, 0);
    chk("clr_out_updates", out_m, 7);
    chk("clr_vld", vld_m, 1);
    cnt_clr = 1'b0;

    // Asynchronous reset mid-stream
    do_reset();
    d = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("ar_pre_out", out_m, 5);
    chk("ar_pre_cnt", cnt_m, 2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vld", vld_m, 0);
    chk("ar_out", out_m, 0);
    chk("ar_cnt", cnt_m, 0);
    chk("ar_any", any_m, 0);
    #1;
    rst = 1'b0;
    tick();
    d = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("ar_first_cnt", cnt_m, 2);

    // Randomised traffic against the reference model
    do_reset();
    m_out = 0; l_out = 0; m_cnt = 0; l_cnt = 0; s_cnt = 0;
    m_vld = 0; m_any = 0; m_multi = 0;
    for (int n = 0; n < 400; n++) begin
      bit acc, rdy_exp;
      int nm, nl;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'(1 << $urandom_range(0, 7));
        default: d = 8'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 19) == 0);
      #1;
      rdy_exp = !m_vld || out_ready;
      chk("rnd_in_ready", in_ready_m, rdy_exp);
      acc = in_valid && rdy_exp;
      if (acc) begin
        nm = ref_idx(d, 1'b1);
        nl = ref_idx(d, 1'b0);
        m_cnt = sat_add(m_cnt, $countones(3'(nm ^ m_out)), 65535);
        s_cnt = sat_add(s_cnt, $countones(3'(nm ^ m_out)), 7);
        l_cnt = sat_add(l_cnt, $countones(3'(nl ^ l_out)), 65535);
        m_out = nm; l_out = nl;
        m_any = (d != 0);
        m_multi = ($countones(d) > 1);
        m_vld = 1'b1;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt = 0; l_cnt = 0; s_cnt = 0;
      end
      tick();
      chk("rnd_out_msb", out_m, m_out);
      chk("rnd_out_lsb", out_l, l_out);
      chk("rnd_any", any_m, m_any);
      chk("rnd_multi", multi_m, m_multi);
      chk("rnd_vld", vld_m, m_vld);
      chk("rnd_cnt_msb", cnt_m, m_cnt);
      chk("rnd_cnt_lsb", cnt_l, l_cnt);
      chk("rnd_cnt_sat", cnt_s, s_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
